// File: rtl/gray_pkg.sv
// Shared constants and helpers for the pipelined binary/Gray converter.
// The conversion functions operate on zero-extended 64-bit words.
package gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int   MAX_W    = 64;

  // Bits resolved per stage of the Gray->binary prefix chain.
  function automatic int gray_chunk(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One elastic register slice: resolves Gray bits [HI:LO] (or does the whole
// binary->Gray step when FIRST) and holds its beat until downstream takes it.
module gray_codec_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HI    = 7,
  parameter int LO    = 4,
  parameter bit FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             mode_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] conv;
  logic             chain;
  logic             load;

  // HI < 0 marks a stage left with an empty slice; it only passes data on.
  always_comb begin
    conv  = data_i;
    chain = carry_i;
    if (mode_i == MODE_G2B) begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          conv[i] = chain ^ data_i[i];
          chain   = conv[i];
        end
      end
    end else if (FIRST) begin
      conv = data_i ^ (data_i >> 1);
    end
  end

  assign load    = !valid_q || ready_i;
  assign ready_o = load;

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (load) begin
      valid_d = valid_i;
      if (valid_i) begin
        mode_d = mode_i;
        data_d = conv;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with per-beat mode and valid/ready flow
// control; the Gray->binary chain is split across STAGES register slices.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             mode_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int C = gray_chunk(WIDTH, STAGES);

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy_pipe;
  logic [STAGES:0]            mode_pipe;
  logic [STAGES:0][WIDTH-1:0] data_pipe;

  assign vld_pipe[0]      = valid_i;
  assign mode_pipe[0]     = mode_i;
  assign data_pipe[0]     = data_i;
  assign rdy_pipe[STAGES] = ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI_RAW = WIDTH - 1 - k * C;
    localparam int LO_RAW = WIDTH - (k + 1) * C;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    logic carry;
    // Carry-in is the binary bit just above this slice, already resolved upstream.
    if (HI_RAW >= WIDTH - 1 || HI_RAW < 0) begin : g_nocarry
      assign carry = 1'b0;
    end else begin : g_carry
      assign carry = data_pipe[k][HI_RAW+1];
    end

    gray_codec_stage #(
      .WIDTH (WIDTH),
      .HI    (HI_RAW),
      .LO    (LO),
      .FIRST (k == 0)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (vld_pipe[k]),
      .ready_o (rdy_pipe[k]),
      .mode_i  (mode_pipe[k]),
      .data_i  (data_pipe[k]),
      .carry_i (carry),
      .valid_o (vld_pipe[k+1]),
      .ready_i (rdy_pipe[k+1]),
      .mode_o  (mode_pipe[k+1]),
      .data_o  (data_pipe[k+1])
    );
  end

  assign ready_o = rst_ni && rdy_pipe[0];
  assign valid_o = vld_pipe[STAGES];
  assign mode_o  = mode_pipe[STAGES];
  assign data_o  = data_pipe[STAGES];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench: four converter builds share one source; each keeps its
// own expected-queue filled on acceptance and drained by a negedge monitor.
module tb_gray_codec_pipe;

  localparam int ND = 4;
  localparam int DW [ND] = '{8, 16, 8, 8};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vin;
  logic        mode;
  logic [15:0] din;
  logic        rdy_i;
  logic [ND-1:0] rdy_o, vld_o, mode_o;
  logic [15:0] dat_o [ND];
  logic [7:0]  d0, d2, d3;
  logic [15:0] d1;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q [ND][$];
  logic [16:0] mon_e;
  logic        prev_hold = 1'b0;
  logic [16:0] prev_out;
  logic        rnd_on;

  always #5 clk = ~clk;

  gray_codec_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vin), .ready_o(rdy_o[0]), .mode_i(mode),
    .data_i(din[7:0]), .valid_o(vld_o[0]), .ready_i(rdy_i), .mode_o(mode_o[0]), .data_o(d0));
  gray_codec_pipe #(.WIDTH(16), .STAGES(3)) u_w16 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vin), .ready_o(rdy_o[1]), .mode_i(mode),
    .data_i(din), .valid_o(vld_o[1]), .ready_i(rdy_i), .mode_o(mode_o[1]), .data_o(d1));
  gray_codec_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vin), .ready_o(rdy_o[2]), .mode_i(mode),
    .data_i(din[7:0]), .valid_o(vld_o[2]), .ready_i(rdy_i), .mode_o(mode_o[2]), .data_o(d2));
  gray_codec_pipe #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vin), .ready_o(rdy_o[3]), .mode_i(mode),
    .data_i(din[7:0]), .valid_o(vld_o[3]), .ready_i(rdy_i), .mode_o(mode_o[3]), .data_o(d3));

  assign dat_o[0] = {8'h00, d0};
  assign dat_o[1] = d1;
  assign dat_o[2] = {8'h00, d2};
  assign dat_o[3] = {8'h00, d3};

  // Reference: Gray = b ^ b/2; binary = XOR of the Gray word shifted by every amount.
  function automatic logic [15:0] ref_conv(input logic m, input logic [15:0] d, input int w);
    logic [15:0] mask, x, r;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    x    = d & mask;
    if (!m) r = x ^ (x >> 1);
    else begin
      r = '0;
      for (int s = 0; s < w; s++) r = r ^ (x >> s);
    end
    return r & mask;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfers are decided by values stable at the negedge before the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) exp_q[d].delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", 32'({mode_o[0], dat_o[0]}), 32'(prev_out));
      prev_hold = vld_o[0] && !rdy_i;
      prev_out  = {mode_o[0], dat_o[0]};
      for (int d = 0; d < ND; d++) begin
        if (vld_o[d] && rdy_i) begin
          if (exp_q[d].size() == 0) chk($sformatf("stale_beat%0d", d), 32'(1), 32'(0));
          else begin
            mon_e = exp_q[d].pop_front();
            chk($sformatf("out%0d", d), 32'({mode_o[d], dat_o[d]}), 32'(mon_e));
          end
        end
        if (vin && rdy_o[d]) exp_q[d].push_back({mode, ref_conv(mode, din, DW[d])});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic m, input logic [15:0] d, output int stalls);
    logic acc;
    vin = 1'b1; mode = m; din = d; stalls = 0;
    forever begin
      @(negedge clk); acc = rdy_o[0];
      @(posedge clk); #1;
      if (acc) break;
      stalls++;
      if (stalls > 300) begin chk("send_timeout", 32'(0), 32'(1)); break; end
    end
  endtask

  task automatic single(input logic m, input logic [15:0] d, input logic [15:0] e0, input logic [15:0] e1);
    int lat0, lat1, st;
    send(m, d, st);
    vin = 1'b0;
    lat0 = 0; lat1 = 0;
    for (int c = 1; c <= 20 && (lat0 == 0 || lat1 == 0); c++) begin
      @(negedge clk);
      if (lat0 == 0 && vld_o[0]) begin lat0 = c; chk("lit8", 32'(dat_o[0]), 32'(e0)); end
      if (lat1 == 0 && vld_o[1]) begin lat1 = c; chk("lit16", 32'(dat_o[1]), 32'(e1)); end
      step();
    end
    chk("latency8", 32'(lat0), 32'(2));
    chk("latency16", 32'(lat1), 32'(3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    rst_n = 1'b0; vin = 1'b0; mode = 1'b0; din = '0; rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_ready%0d", d), 32'(rdy_o[d]), 32'(0));
      chk($sformatf("rst_valid%0d", d), 32'(vld_o[d]), 32'(0));
      chk($sformatf("rst_data%0d", d), 32'(dat_o[d]), 32'(0));
      chk($sformatf("rst_mode%0d", d), 32'(mode_o[d]), 32'(0));
    end
    step(); rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rel_ready%0d", d), 32'(rdy_o[d]), 32'(1));
      chk($sformatf("idle_valid%0d", d), 32'(vld_o[d]), 32'(0));
    end
    step();

    single(1'b0, 16'h005A, 16'h0077, 16'h0077);
    single(1'b1, 16'h0077, 16'h005A, 16'h005A);
    single(1'b1, 16'h00FF, 16'h00AA, 16'h00AA);
    single(1'b1, 16'h8000, 16'h0000, 16'hFFFF);
    single(1'b0, 16'hFFFF, 16'h0080, 16'h8000);

    // Back-to-back sweep, alternating mode: must never stall.
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      send(1'(i % 2), {8'($urandom()), 8'(i)}, st);
      tot += st;
    end
    vin = 1'b0;
    chk("sweep_stalls", 32'(tot), 32'(0));
    repeat (20) step();

    // Fill with ready_i low: two beats fit, the third waits.
    rdy_i = 1'b0; vin = 1'b1; mode = 1'b0; din = 16'h0011;
    @(negedge clk); chk("bp_acc1", 32'(rdy_o[0]), 32'(1));
    step(); din = 16'h0022; mode = 1'b1;
    @(negedge clk); chk("bp_acc2", 32'(rdy_o[0]), 32'(1));
    step(); din = 16'h0033; mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("bp_full", 32'(rdy_o[0]), 32'(0));
      step();
    end
    rdy_i = 1'b1;
    @(negedge clk); chk("bp_release", 32'(rdy_o[0]), 32'(1));
    step(); vin = 1'b0;
    repeat (20) step();

    // Random backpressure with random bubbles.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin step(); rdy_i = ($urandom_range(0, 3) != 0); end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          send(1'($urandom_range(0, 1)), 16'($urandom()), st);
          if ($urandom_range(0, 4) == 0) begin vin = 1'b0; step(); end
        end
        vin = 1'b0; rnd_on = 1'b0;
      end
    join
    rdy_i = 1'b1;
    repeat (30) step();

    // Reset with two beats in flight.
    rdy_i = 1'b0;
    send(1'b0, 16'h00C3, st);
    send(1'b1, 16'h003C, st);
    vin = 1'b0;
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk($sformatf("midrst_valid%0d", d), 32'(vld_o[d]), 32'(0));
    step(); rdy_i = 1'b1;
    repeat (30) step();

    for (int d = 0; d < ND; d++) chk($sformatf("drained%0d", d), 32'(exp_q[d].size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
